// File: rtl/e64x6_scan_encoder_if.sv
// Handshake bundle for the 64-to-6 scan encoder: vector load side and index stream side.
// out_count is present only when E64X6_COUNT_EN is defined.
interface e64x6_scan_encoder_if;
  logic        load_valid;
  logic        load_ready;
  logic [63:0] input_line;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_index;
  logic        out_last;
`ifdef E64X6_COUNT_EN
  logic [6:0]  out_count;
`endif

  modport master (
    output load_valid, input_line, out_ready,
    input  load_ready, out_valid, out_index, out_last
`ifdef E64X6_COUNT_EN
    , input out_count
`endif
  );

  modport slave (
    input  load_valid, input_line, out_ready,
    output load_ready, out_valid, out_index, out_last
`ifdef E64X6_COUNT_EN
    , output out_count
`endif
  );
endinterface

// File: rtl/e64x6_scan_encoder.sv
// Sequential 64-to-6 encoder: serializes the set-bit positions of a loaded vector, lowest first.
// Optional macro E64X6_COUNT_EN adds a registered popcount of each accepted vector.
module e64x6_scan_encoder (
  input  logic                 clk,
  input  logic                 reset,
  e64x6_scan_encoder_if.slave  bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]  state;
  logic [63:0] pending;
  logic [5:0]  low_idx;
  logic        one_left;

  // Scan from the top so the lowest set bit is the last (winning) assignment.
  always_comb begin
    low_idx = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (pending[i]) low_idx = 6'(i);
    end
  end

  assign one_left = (pending != 64'd0) && ((pending & (pending - 64'd1)) == 64'd0);

  // All outputs come from registered state; nothing is steered by the inputs.
  assign bus.load_ready = (state == ST_IDLE);
  assign bus.out_valid  = (state == ST_EMIT);
  assign bus.out_index  = low_idx;
  assign bus.out_last   = (state == ST_EMIT) && one_left;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= 64'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.load_valid) begin
            pending <= bus.input_line;
            if (bus.input_line != 64'd0) state <= ST_EMIT;
          end
        end
        default: begin
          if (bus.out_ready) begin
            // Clearing the lowest set bit retires exactly the index on out_index.
            pending <= pending & (pending - 64'd1);
            if (one_left) state <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef E64X6_COUNT_EN
  function automatic logic [6:0] popcnt(input logic [63:0] v);
    logic [6:0] s;
    s = 7'd0;
    for (int i = 0; i < 64; i++) s = s + {6'd0, v[i]};
    return s;
  endfunction

  logic [6:0] count_q;

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= 7'd0;
    else if (state == ST_IDLE && bus.load_valid)
      count_q <= popcnt(bus.input_line);
  end

  assign bus.out_count = count_q;
`endif
endmodule

// File: tb/tb_e64x6_scan_encoder.sv
// Directed bench for e64x6_scan_encoder; inputs driven and outputs sampled on the falling edge.
module tb_e64x6_scan_encoder;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  e64x6_scan_encoder_if bus ();

  e64x6_scan_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {load_ready, out_valid, out_last, out_index}
  logic [8:0] obs;
  assign obs = {bus.load_ready, bus.out_valid, bus.out_last, bus.out_index};

  localparam logic [8:0] IDLE_OBS = {1'b1, 1'b0, 1'b0, 6'd0};

  task automatic test_reset();
    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.input_line = 64'd0;
    bus.out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (obs !== IDLE_OBS) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, IDLE_OBS);
    end
`ifdef E64X6_COUNT_EN
    total++;
    if (bus.out_count !== 7'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d exp=0", bus.out_count);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_single();
    bus.load_valid = 1'b1;
    bus.input_line = 64'h0000_0000_0000_0001;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    total++;
    if (obs !== {1'b0, 1'b1, 1'b1, 6'd0}) begin
      bad++;
      $display("FAIL single_emit got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 6'd0});
    end
    @(negedge clk);
    total++;
    if (obs !== IDLE_OBS) begin
      bad++;
      $display("FAIL single_ready got=%h exp=%h", obs, IDLE_OBS);
    end
  endtask

  task automatic test_multi();
    logic [5:0] exp_idx [3];
    logic [8:0] e;
    exp_idx[0] = 6'd0; exp_idx[1] = 6'd4; exp_idx[2] = 6'd63;
    bus.load_valid = 1'b1;
    bus.input_line = 64'h8000_0000_0000_0011;
    bus.out_ready  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.load_valid = 1'b0;
      e = {1'b0, 1'b1, (k == 2), exp_idx[k]};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL multi_idx%0d got=%h exp=%h", k, obs, e);
      end
`ifdef E64X6_COUNT_EN
      total++;
      if (bus.out_count !== 7'd3) begin
        bad++;
        $display("FAIL multi_count got=%0d exp=3", bus.out_count);
      end
`endif
    end
    @(negedge clk);
    total++;
    if (obs !== IDLE_OBS) begin
      bad++;
      $display("FAIL multi_done got=%h exp=%h", obs, IDLE_OBS);
    end
  endtask

  task automatic test_stall();
    bus.load_valid = 1'b1;
    bus.input_line = 64'h0000_0000_0000_0006;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (obs !== {1'b0, 1'b1, 1'b0, 6'd1}) begin
        bad++;
        $display("FAIL stall_hold%0d got=%h exp=%h", k, obs, {1'b0, 1'b1, 1'b0, 6'd1});
      end
      // These load pulses arrive while emitting and must be ignored.
      bus.load_valid = k[0];
      bus.input_line = 64'hFFFF_FFFF_FFFF_FFFF;
      if (k < 4) @(negedge clk);
    end
    bus.load_valid = 1'b0;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== {1'b0, 1'b1, 1'b1, 6'd2}) begin
      bad++;
      $display("FAIL stall_second got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 6'd2});
    end
`ifdef E64X6_COUNT_EN
    total++;
    if (bus.out_count !== 7'd2) begin
      bad++;
      $display("FAIL stall_count got=%0d exp=2", bus.out_count);
    end
`endif
    @(negedge clk);
    total++;
    if (obs !== IDLE_OBS) begin
      bad++;
      $display("FAIL stall_done got=%h exp=%h", obs, IDLE_OBS);
    end
  endtask

  task automatic test_zero();
    bus.load_valid = 1'b1;
    bus.input_line = 64'd0;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== IDLE_OBS) begin
      bad++;
      $display("FAIL zero_idle got=%h exp=%h", obs, IDLE_OBS);
    end
`ifdef E64X6_COUNT_EN
    total++;
    if (bus.out_count !== 7'd0) begin
      bad++;
      $display("FAIL zero_count got=%0d exp=0", bus.out_count);
    end
`endif
    bus.input_line = 64'h4;
    @(negedge clk);
    bus.load_valid = 1'b0;
    total++;
    if (obs !== {1'b0, 1'b1, 1'b1, 6'd2}) begin
      bad++;
      $display("FAIL zero_next got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 6'd2});
    end
    @(negedge clk);
    total++;
    if (obs !== IDLE_OBS) begin
      bad++;
      $display("FAIL zero_done got=%h exp=%h", obs, IDLE_OBS);
    end
  endtask

  task automatic test_back_to_back();
    bus.load_valid = 1'b1;
    bus.input_line = 64'h8000_0000_0000_0000;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    total++;
    if (obs !== {1'b0, 1'b1, 1'b1, 6'b111111}) begin
      bad++;
      $display("FAIL b2b_top got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 6'b111111});
    end
    @(negedge clk);
    total++;
    if (obs !== IDLE_OBS) begin
      bad++;
      $display("FAIL b2b_ready got=%h exp=%h", obs, IDLE_OBS);
    end
    bus.load_valid = 1'b1;
    bus.input_line = 64'h3;
    @(negedge clk);
    bus.load_valid = 1'b0;
    total++;
    if (obs !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
      bad++;
      $display("FAIL b2b_first got=%h exp=%h", obs, {1'b0, 1'b1, 1'b0, 6'd0});
    end
    @(negedge clk);
    total++;
    if (obs !== {1'b0, 1'b1, 1'b1, 6'd1}) begin
      bad++;
      $display("FAIL b2b_second got=%h exp=%h", obs, {1'b0, 1'b1, 1'b1, 6'd1});
    end
    @(negedge clk);
  endtask

  task automatic test_all_ones_reset();
    logic [8:0] e;
    bus.load_valid = 1'b1;
    bus.input_line = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.out_ready  = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      bus.load_valid = 1'b0;
      e = {1'b0, 1'b1, 1'b0, 6'(k)};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL ones_idx%0d got=%h exp=%h", k, obs, e);
      end
`ifdef E64X6_COUNT_EN
      total++;
      if (bus.out_count !== 7'd64) begin
        bad++;
        $display("FAIL ones_count got=%0d exp=64", bus.out_count);
      end
`endif
    end
    // Ten indices taken; reset collides with the handshake of index 10.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (obs !== IDLE_OBS) begin
      bad++;
      $display("FAIL ones_reset got=%h exp=%h", obs, IDLE_OBS);
    end
`ifdef E64X6_COUNT_EN
    total++;
    if (bus.out_count !== 7'd0) begin
      bad++;
      $display("FAIL ones_reset_count got=%0d exp=0", bus.out_count);
    end
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL ones_abandon%0d got=%b exp=0", k, bus.out_valid);
      end
    end
  endtask

  task automatic test_all_ones_full();
    logic [8:0] e;
    bus.load_valid = 1'b1;
    bus.input_line = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.out_ready  = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      bus.load_valid = 1'b0;
      e = {1'b0, 1'b1, (k == 63), 6'(k)};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL full_idx%0d got=%h exp=%h", k, obs, e);
      end
    end
    @(negedge clk);
    total++;
    if (obs !== IDLE_OBS) begin
      bad++;
      $display("FAIL full_done got=%h exp=%h", obs, IDLE_OBS);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.input_line = 64'd0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_zero();
    test_back_to_back();
    test_all_ones_full();
    test_all_ones_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/e64x6_scan_encoder.md
# e64x6_scan_encoder

Sequential 64-to-6 encoder: captures a 64-bit request vector and emits the 6-bit index of every set bit, lowest first, one index per output handshake. It is the inverse companion of the 6-to-64 decoder: indices produced here, fed back through the decoder, reconstruct the original vector bit by bit. It sits between request-collection logic and any consumer that wants a serialized stream of bit positions.

## Interface
Parameters: none. The widths are fixed at 64 input bits and a 6-bit index.

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  producer presents a vector on input_line
- load_ready  out  1  block can accept a new vector
- input_line  in  64  request vector; bit i set means index i is pending
- out_valid  out  1  out_index holds a valid index
- out_ready  in  1  consumer accepts out_index
- out_index  out  6  index of the lowest pending set bit
- out_last  out  1  the current index is the final pending bit of this vector
- out_count  out  7  popcount of the loaded vector; present only with E64X6_COUNT_EN

## Operation
- State register `pending[63:0]`. FSM has two states: IDLE and EMIT.
- Reset value of every output:
  - load_ready = 1
  - out_valid = 0
  - out_index = 0
  - out_last = 0
  - out_count = 0
- Reset also clears pending and sets the state to IDLE.
- IDLE:
  - load_ready = 1.
  - On load_valid=1, pending <= input_line.
  - If input_line is non-zero, go to EMIT.
  - If input_line is all zero, the vector is accepted, nothing is emitted, and the block stays in IDLE.
- EMIT:
  - load_ready = 0.
  - out_valid = 1.
  - out_index = position of the lowest set bit of pending (priority: bit 0 is highest).
  - out_last = 1 exactly when pending has one bit set.
- Output handshake:
  - On out_valid && out_ready, clear that bit in pending.
  - If out_last is also 1, return to IDLE.
- Outputs are decoded from registered state only. There is no combinational path from input_line, load_valid or out_ready to any output.
- Stall rule: while out_valid=1 and out_ready=0, out_index, out_last and pending hold stable.
- load_valid asserted during EMIT is ignored. input_line is not sampled.
- reset asserted mid-EMIT:
  - The next edge abandons the vector.
  - All outputs go to their reset values.
  - No further index is emitted for that vector.

## Timing
- Load handshake at edge N → out_valid=1 with the first index from cycle N+1.
- Throughput is one index per cycle while out_ready is held at 1. A vector with k bits set drains in k cycles.
- Last handshake at edge M → load_ready=1 in cycle M+1. The next vector can be accepted at edge M+1.
- Minimum period per vector is k+1 cycles (k ≥ 1). An all-zero vector takes 1 cycle.
- Index 63 → out_index = 6'b111111. There is no wrap-around; bit 63 is always emitted last.
- Simultaneous reset with a load or output handshake: reset wins. No capture happens and no bit is cleared.

## Configuration
- Macro `E64X6_COUNT_EN`.
- Defined:
  - Port out_count[6:0] exists.
  - It registers the popcount of input_line on each accepted load, including zero vectors.
  - The value holds until the next load or reset.
  - Range is 0–64: all-ones gives 7'd64.
- Undefined:
  - Port and popcount logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then load 64'h0000_0000_0000_0001 with out_ready=1:
  - out_index=0 and out_last=1 for one cycle.
  - load_ready=1 on the following cycle.
- Load 64'h8000_0000_0000_0011 with out_ready=1:
  - Emits indices 0, 4, 63 on consecutive cycles; out_last=1 only on 63.
  - out_count=3 with the macro defined.
- Load 64'h0000_0000_0000_0006, then hold out_ready=0 for 5 cycles:
  - out_index stays 1, out_last stays 0.
  - After release, emits 1 then 2 (out_last=1).
  - load_valid pulses during the stall are ignored.
- Load all-zero:
  - No out_valid, load_ready stays 1, out_count=0.
  - A following load of 64'h4 is accepted on the next edge and emits index 2.
- Load all-ones:
  - 64 consecutive indices 0..63, out_last only on 63, out_count=64.
  - Assert reset after 10 indices: the next cycle has out_valid=0 and load_ready=1, and the remaining bits are never emitted.
